// File: rtl/axi4_arbiter_2to1.sv
`default_nettype none
// axi4_arbiter_2to1: round-robin 2:1 AXI4 arbiter, independent read/write paths,
// one outstanding transaction per path, bursts never interleaved. Rev 1.0
module axi4_arbiter_2to1 #(
   parameter int ID_W   = 4,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                          clock,
   input  logic                          reset,
   // master 0 (IFU)
   input  logic                          m0_arvalid,
   output logic                          m0_arready,
   input  logic [ID_W+ADDR_W+13-1:0]     m0_ar,
   output logic                          m0_rvalid,
   input  logic                          m0_rready,
   output logic [ID_W+DATA_W+3-1:0]      m0_r,
   input  logic                          m0_awvalid,
   output logic                          m0_awready,
   input  logic [ID_W+ADDR_W+13-1:0]     m0_aw,
   input  logic                          m0_wvalid,
   output logic                          m0_wready,
   input  logic [DATA_W+DATA_W/8+1-1:0]  m0_w,
   output logic                          m0_bvalid,
   input  logic                          m0_bready,
   output logic [ID_W+2-1:0]             m0_b,
   // master 1 (LSU)
   input  logic                          m1_arvalid,
   output logic                          m1_arready,
   input  logic [ID_W+ADDR_W+13-1:0]     m1_ar,
   output logic                          m1_rvalid,
   input  logic                          m1_rready,
   output logic [ID_W+DATA_W+3-1:0]      m1_r,
   input  logic                          m1_awvalid,
   output logic                          m1_awready,
   input  logic [ID_W+ADDR_W+13-1:0]     m1_aw,
   input  logic                          m1_wvalid,
   output logic                          m1_wready,
   input  logic [DATA_W+DATA_W/8+1-1:0]  m1_w,
   output logic                          m1_bvalid,
   input  logic                          m1_bready,
   output logic [ID_W+2-1:0]             m1_b,
   // shared slave port
   output logic                          s_arvalid,
   input  logic                          s_arready,
   output logic [ID_W+ADDR_W+13-1:0]     s_ar,
   input  logic                          s_rvalid,
   output logic                          s_rready,
   input  logic [ID_W+DATA_W+3-1:0]      s_r,
   output logic                          s_awvalid,
   input  logic                          s_awready,
   output logic [ID_W+ADDR_W+13-1:0]     s_aw,
   output logic                          s_wvalid,
   input  logic                          s_wready,
   output logic [DATA_W+DATA_W/8+1-1:0]  s_w,
   input  logic                          s_bvalid,
   output logic                          s_bready,
   input  logic [ID_W+2-1:0]             s_b
);

   typedef enum logic [1:0] {RD_IDLE = 2'd0, RD_ADDR = 2'd1, RD_DATA = 2'd2} rd_state_t;
   typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_XFER = 2'd1, WR_RESP = 2'd2} wr_state_t;

   rd_state_t rd_state_q, rd_state_d;
   wr_state_t wr_state_q, wr_state_d;
   logic      rd_gnt_q, rd_gnt_d;
   logic      last_rd_q, last_rd_d;
   logic      wr_gnt_q, wr_gnt_d;
   logic      last_wr_q, last_wr_d;
   logic      aw_done_q, aw_done_d;
   logic      w_done_q, w_done_d;

   // granted-master selections; grant register value 1 means m1
   logic                         rd_arvalid, rd_rready;
   logic [ID_W+ADDR_W+13-1:0]    rd_ar;
   logic                         wr_awvalid, wr_wvalid, wr_bready;
   logic [ID_W+ADDR_W+13-1:0]    wr_aw;
   logic [DATA_W+DATA_W/8+1-1:0] wr_w;
   logic                         aw_hs, w_last_hs;

   assign rd_arvalid = rd_gnt_q ? m1_arvalid : m0_arvalid;
   assign rd_ar      = rd_gnt_q ? m1_ar      : m0_ar;
   assign rd_rready  = rd_gnt_q ? m1_rready  : m0_rready;
   assign wr_awvalid = wr_gnt_q ? m1_awvalid : m0_awvalid;
   assign wr_aw      = wr_gnt_q ? m1_aw      : m0_aw;
   assign wr_wvalid  = wr_gnt_q ? m1_wvalid  : m0_wvalid;
   assign wr_w       = wr_gnt_q ? m1_w       : m0_w;
   assign wr_bready  = wr_gnt_q ? m1_bready  : m0_bready;

   // AW and W each close once; their handshakes only count in WR_XFER
   assign aw_hs     = (wr_state_q == WR_XFER) && !aw_done_q && wr_awvalid && s_awready;
   assign w_last_hs = (wr_state_q == WR_XFER) && !w_done_q && wr_wvalid && s_wready && wr_w[0];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_state_q <= RD_IDLE;
         rd_gnt_q   <= 1'b0;
         last_rd_q  <= 1'b1;
         wr_state_q <= WR_IDLE;
         wr_gnt_q   <= 1'b0;
         last_wr_q  <= 1'b1;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
      end else begin
         rd_state_q <= rd_state_d;
         rd_gnt_q   <= rd_gnt_d;
         last_rd_q  <= last_rd_d;
         wr_state_q <= wr_state_d;
         wr_gnt_q   <= wr_gnt_d;
         last_wr_q  <= last_wr_d;
         aw_done_q  <= aw_done_d;
         w_done_q   <= w_done_d;
      end
   end

   always_comb begin
      rd_state_d = rd_state_q;
      rd_gnt_d   = rd_gnt_q;
      last_rd_d  = last_rd_q;
      s_arvalid  = 1'b0;
      s_ar       = '0;
      s_rready   = 1'b0;
      m0_arready = 1'b0;
      m1_arready = 1'b0;
      m0_rvalid  = 1'b0;
      m1_rvalid  = 1'b0;
      m0_r       = '0;
      m1_r       = '0;
      case (rd_state_q)
         RD_IDLE: begin
            if (m0_arvalid && m1_arvalid) begin
               rd_gnt_d   = ~last_rd_q;
               rd_state_d = RD_ADDR;
            end else if (m0_arvalid) begin
               rd_gnt_d   = 1'b0;
               rd_state_d = RD_ADDR;
            end else if (m1_arvalid) begin
               rd_gnt_d   = 1'b1;
               rd_state_d = RD_ADDR;
            end
         end
         RD_ADDR: begin
            s_arvalid = rd_arvalid;
            s_ar      = rd_ar;
            if (rd_gnt_q) m1_arready = s_arready;
            else          m0_arready = s_arready;
            if (rd_arvalid && s_arready) rd_state_d = RD_DATA;
         end
         RD_DATA: begin
            s_rready = rd_rready;
            if (rd_gnt_q) begin
               m1_rvalid = s_rvalid;
               m1_r      = s_r;
            end else begin
               m0_rvalid = s_rvalid;
               m0_r      = s_r;
            end
            if (s_rvalid && rd_rready && s_r[0]) begin
               last_rd_d  = rd_gnt_q;
               rd_state_d = RD_IDLE;
            end
         end
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      wr_state_d = wr_state_q;
      wr_gnt_d   = wr_gnt_q;
      last_wr_d  = last_wr_q;
      aw_done_d  = aw_done_q;
      w_done_d   = w_done_q;
      s_awvalid  = 1'b0;
      s_aw       = '0;
      s_wvalid   = 1'b0;
      s_w        = '0;
      s_bready   = 1'b0;
      m0_awready = 1'b0;
      m1_awready = 1'b0;
      m0_wready  = 1'b0;
      m1_wready  = 1'b0;
      m0_bvalid  = 1'b0;
      m1_bvalid  = 1'b0;
      m0_b       = '0;
      m1_b       = '0;
      case (wr_state_q)
         WR_IDLE: begin
            if (m0_awvalid && m1_awvalid) begin
               wr_gnt_d   = ~last_wr_q;
               wr_state_d = WR_XFER;
            end else if (m0_awvalid) begin
               wr_gnt_d   = 1'b0;
               wr_state_d = WR_XFER;
            end else if (m1_awvalid) begin
               wr_gnt_d   = 1'b1;
               wr_state_d = WR_XFER;
            end
         end
         WR_XFER: begin
            if (!aw_done_q) begin
               s_awvalid = wr_awvalid;
               s_aw      = wr_aw;
               if (wr_gnt_q) m1_awready = s_awready;
               else          m0_awready = s_awready;
            end
            if (!w_done_q) begin
               s_wvalid = wr_wvalid;
               s_w      = wr_w;
               if (wr_gnt_q) m1_wready = s_wready;
               else          m0_wready = s_wready;
            end
            aw_done_d = aw_done_q || aw_hs;
            w_done_d  = w_done_q || w_last_hs;
            if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
         end
         WR_RESP: begin
            s_bready = wr_bready;
            if (wr_gnt_q) begin
               m1_bvalid = s_bvalid;
               m1_b      = s_b;
            end else begin
               m0_bvalid = s_bvalid;
               m0_b      = s_b;
            end
            if (s_bvalid && wr_bready) begin
               aw_done_d  = 1'b0;
               w_done_d   = 1'b0;
               last_wr_d  = wr_gnt_q;
               wr_state_d = WR_IDLE;
            end
         end
         default: wr_state_d = WR_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_axi4_arbiter_2to1.sv
`default_nettype none
// tb_axi4_arbiter_2to1: directed vector bench for the 2:1 AXI4 arbiter.
module tb_axi4_arbiter_2to1;

   localparam int ID_W = 4, ADDR_W = 32, DATA_W = 32;
   localparam int AX_W = ID_W + ADDR_W + 13;
   localparam int R_W  = ID_W + DATA_W + 3;
   localparam int W_W  = DATA_W + DATA_W / 8 + 1;
   localparam int B_W  = ID_W + 2;

   logic clock = 1'b0;
   logic reset;
   logic            m0_arvalid, m0_arready, m0_rvalid, m0_rready, m0_awvalid, m0_awready;
   logic            m0_wvalid, m0_wready, m0_bvalid, m0_bready;
   logic [AX_W-1:0] m0_ar, m0_aw;
   logic [R_W-1:0]  m0_r;
   logic [W_W-1:0]  m0_w;
   logic [B_W-1:0]  m0_b;
   logic            m1_arvalid, m1_arready, m1_rvalid, m1_rready, m1_awvalid, m1_awready;
   logic            m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic [AX_W-1:0] m1_ar, m1_aw;
   logic [R_W-1:0]  m1_r;
   logic [W_W-1:0]  m1_w;
   logic [B_W-1:0]  m1_b;
   logic            s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
   logic            s_wvalid, s_wready, s_bvalid, s_bready;
   logic [AX_W-1:0] s_ar, s_aw;
   logic [R_W-1:0]  s_r;
   logic [W_W-1:0]  s_w;
   logic [B_W-1:0]  s_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   axi4_arbiter_2to1 #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_ar(m0_ar),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_r(m0_r),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_aw(m0_aw),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_w(m0_w),
      .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_b(m0_b),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_ar(m1_ar),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_r(m1_r),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_aw(m1_aw),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_w(m1_w),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_b(m1_b),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_ar(s_ar),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_r(s_r),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_aw(s_aw),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_w(s_w),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_b(s_b)
   );

   typedef struct {
      bit          req0;
      bit          req1;
      bit          exp;
      logic [7:0]  len;
      logic [31:0] data;
      logic [1:0]  resp;
   } rd_vec_t;

   rd_vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [AX_W-1:0] mk_ax(input logic [3:0] id, input logic [31:0] addr,
                                             input logic [7:0] len);
      return {id, addr, len, 3'd2, 2'd1};
   endfunction

   // One read transaction: request, address phase, len+1 data beats, back to idle.
   task automatic read_txn(input rd_vec_t v);
      logic [AX_W-1:0] ar_exp;
      logic [R_W-1:0]  r_exp;
      logic [3:0]      id_exp;
      m0_ar  = mk_ax(4'd1, 32'h3000_0000, v.len);
      m1_ar  = mk_ax(4'd2, 32'h4000_0000, v.len);
      ar_exp = v.exp ? m1_ar : m0_ar;
      id_exp = v.exp ? 4'd2 : 4'd1;
      m0_arvalid = v.req0;
      m1_arvalid = v.req1;
      #1;
      check("ar_idle_no_pass", s_arvalid, 0);
      check("ar_idle_ready", v.exp ? m1_arready : m0_arready, 0);
      @(posedge clock); #1;
      check("ar_valid", s_arvalid, 1);
      check("ar_payload", s_ar, ar_exp);
      s_arready = 1'b1;
      #1;
      check("ar_ready_gnt", v.exp ? m1_arready : m0_arready, 1);
      check("ar_ready_other", v.exp ? m0_arready : m1_arready, 0);
      @(posedge clock); #1;
      s_arready = 1'b0;
      if (v.exp) m1_arvalid = 1'b0;
      else       m0_arvalid = 1'b0;
      for (int b = 0; b <= int'(v.len); b++) begin
         r_exp     = {id_exp, v.data + 32'(b), v.resp, (b == int'(v.len))};
         s_r       = r_exp;
         s_rvalid  = 1'b1;
         m0_rready = 1'b1;
         m1_rready = 1'b1;
         #1;
         check("r_valid_gnt", v.exp ? m1_rvalid : m0_rvalid, 1);
         check("r_payload", v.exp ? m1_r : m0_r, r_exp);
         check("r_valid_other", v.exp ? m0_rvalid : m1_rvalid, 0);
         check("r_payload_other", v.exp ? m0_r : m1_r, 0);
         check("s_rready_data", s_rready, 1);
         check("ar_held_in_burst", s_arvalid, 0);
         @(posedge clock); #1;
      end
      #1;
      check("rd_idle_rready", s_rready, 0);
      check("rd_idle_rvalid", v.exp ? m1_rvalid : m0_rvalid, 0);
      s_rvalid  = 1'b0;
      m0_rready = 1'b0;
      m1_rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      {m0_arvalid, m0_rready, m0_awvalid, m0_wvalid, m0_bready} = '0;
      {m1_arvalid, m1_rready, m1_awvalid, m1_wvalid, m1_bready} = '0;
      {s_arready, s_rvalid, s_awready, s_wready, s_bvalid} = '0;
      m0_ar = '0; m0_aw = '0; m0_w = '0;
      m1_ar = '0; m1_aw = '0; m1_w = '0;
      s_r = '0; s_b = '0;

      // row: req0 req1 exp len data resp
      vecs[0] = '{1'b1, 1'b0, 1'b0, 8'd0, 32'hDEADBEEF, 2'd0};
      vecs[1] = '{1'b0, 1'b1, 1'b1, 8'd1, 32'h1111_0000, 2'd0};
      vecs[2] = '{1'b1, 1'b0, 1'b0, 8'd3, 32'h2222_0000, 2'd2};
      vecs[3] = '{1'b0, 1'b1, 1'b1, 8'd0, 32'h3333_0000, 2'd1};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 8'd3, 32'hA000_0000, 2'd0};
      vecs[5] = '{1'b1, 1'b1, 1'b1, 8'd3, 32'hB000_0000, 2'd0};
      vecs[6] = '{1'b1, 1'b1, 1'b0, 8'd3, 32'hC000_0000, 2'd0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 8'd2, 32'hD000_0000, 2'd3};

      // reset state, with requests already asserted
      m0_arvalid = 1'b1;
      m1_awvalid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("rst_s_arvalid", s_arvalid, 0);
      check("rst_s_awvalid", s_awvalid, 0);
      check("rst_m0_arready", m0_arready, 0);
      check("rst_m1_awready", m1_awready, 0);
      check("rst_s_rready", s_rready, 0);
      check("rst_s_bready", s_bready, 0);
      check("rst_s_ar", s_ar, 0);
      m0_arvalid = 1'b0;
      m1_awvalid = 1'b0;
      reset = 1'b0;
      @(posedge clock); #1;

      // stray B response in WR_IDLE is held off
      s_bvalid = 1'b1;
      s_b      = {4'd3, 2'd0};
      m0_bready = 1'b1;
      m1_bready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("stray_b_bready", s_bready, 0);
         check("stray_b_m0", m0_bvalid, 0);
         check("stray_b_m1", m1_bvalid, 0);
         @(posedge clock); #1;
      end
      m0_bready = 1'b0;
      m1_bready = 1'b0;

      for (int i = 0; i < 8; i++) read_txn(vecs[i]);

      // m1 write: W handshake two cycles before AW
      m1_aw = mk_ax(4'd2, 32'h5000_0000, 8'd0);
      m1_w  = {32'h12345678, 4'hF, 1'b1};
      m1_awvalid = 1'b1;
      m1_wvalid  = 1'b1;
      #1;
      check("wr_idle_no_pass", s_awvalid, 0);
      @(posedge clock); #1;
      s_wready  = 1'b1;
      s_awready = 1'b0;
      #1;
      check("w_valid", s_wvalid, 1);
      check("w_payload", s_w, {32'h12345678, 4'hF, 1'b1});
      check("w_ready_m1", m1_wready, 1);
      check("w_ready_m0", m0_wready, 0);
      check("aw_valid_pending", s_awvalid, 1);
      @(posedge clock); #1;
      check("w_closed_valid", s_wvalid, 0);
      check("w_closed_ready", m1_wready, 0);
      check("aw_still_pending", s_awvalid, 1);
      @(posedge clock); #1;
      s_awready = 1'b1;
      #1;
      check("aw_ready_m1", m1_awready, 1);
      check("aw_payload", s_aw, mk_ax(4'd2, 32'h5000_0000, 8'd0));
      @(posedge clock); #1;
      s_awready  = 1'b0;
      s_wready   = 1'b0;
      m1_awvalid = 1'b0;
      m1_wvalid  = 1'b0;
      s_bvalid   = 1'b1;
      s_b        = {4'd2, 2'd0};
      m1_bready  = 1'b1;
      #1;
      check("aw_done_valid", s_awvalid, 0);
      check("b_valid_m1", m1_bvalid, 1);
      check("b_payload_m1", m1_b, {4'd2, 2'd0});
      check("b_valid_m0", m0_bvalid, 0);
      check("b_bready", s_bready, 1);
      @(posedge clock); #1;
      check("wr_idle_bready", s_bready, 0);
      check("wr_idle_bvalid", m1_bvalid, 0);
      s_bvalid  = 1'b0;
      m1_bready = 1'b0;

      // concurrent m0 read and m1 write, masters stall responses 5 cycles
      m0_ar = mk_ax(4'd1, 32'h3000_1000, 8'd0);
      m1_aw = mk_ax(4'd2, 32'h5000_2000, 8'd0);
      m1_w  = {32'hA5A5_5A5A, 4'h3, 1'b1};
      m0_arvalid = 1'b1;
      m1_awvalid = 1'b1;
      m1_wvalid  = 1'b1;
      @(posedge clock); #1;
      s_arready = 1'b1;
      s_awready = 1'b1;
      s_wready  = 1'b1;
      #1;
      check("cc_ar_id", s_ar[AX_W-1 -: 4], 4'd1);
      check("cc_aw_id", s_aw[AX_W-1 -: 4], 4'd2);
      check("cc_ar_ready", m0_arready, 1);
      check("cc_aw_ready", m1_awready, 1);
      @(posedge clock); #1;
      {s_arready, s_awready, s_wready} = '0;
      {m0_arvalid, m1_awvalid, m1_wvalid} = '0;
      s_rvalid = 1'b1;
      s_r      = {4'd1, 32'h0BAD_F00D, 2'd0, 1'b1};
      s_bvalid = 1'b1;
      s_b      = {4'd2, 2'd0};
      for (int i = 0; i < 5; i++) begin
         #1;
         check("cc_stall_rready", s_rready, 0);
         check("cc_stall_bready", s_bready, 0);
         check("cc_stall_rvalid", m0_rvalid, 1);
         check("cc_stall_bvalid", m1_bvalid, 1);
         @(posedge clock); #1;
      end
      m0_rready = 1'b1;
      m1_bready = 1'b1;
      #1;
      check("cc_r_m0", m0_r, {4'd1, 32'h0BAD_F00D, 2'd0, 1'b1});
      check("cc_b_m1", m1_b, {4'd2, 2'd0});
      check("cc_no_r_m1", m1_rvalid, 0);
      check("cc_no_b_m0", m0_bvalid, 0);
      @(posedge clock); #1;
      check("cc_done_rready", s_rready, 0);
      check("cc_done_bready", s_bready, 0);
      {s_rvalid, s_bvalid, m0_rready, m1_bready} = '0;

      // reset during beat 2 of an 8-beat m1 read (m0 was last read winner)
      m1_ar = mk_ax(4'd2, 32'h4000_8000, 8'd7);
      m1_arvalid = 1'b1;
      @(posedge clock); #1;
      s_arready = 1'b1;
      @(posedge clock); #1;
      s_arready  = 1'b0;
      m1_arvalid = 1'b0;
      m1_rready  = 1'b1;
      for (int b = 0; b < 3; b++) begin
         s_rvalid = 1'b1;
         s_r      = {4'd2, 32'h7700_0000 + 32'(b), 2'd0, 1'b0};
         #1;
         check("rst_burst_beat", m1_rvalid, 1);
         if (b < 2) begin
            @(posedge clock); #1;
         end
      end
      reset = 1'b1;
      #1;
      check("midrst_m1_rvalid", m1_rvalid, 0);
      check("midrst_m1_r", m1_r, 0);
      check("midrst_s_rready", s_rready, 0);
      @(posedge clock); #1;
      reset     = 1'b0;
      s_rvalid  = 1'b0;
      m1_rready = 1'b0;
      @(posedge clock); #1;
      read_txn('{1'b1, 1'b1, 1'b0, 8'd0, 32'hCAFE_0000, 2'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
